// File: rtl/demux_l0_pkg.sv
// Shared defaults and state type for the lane-0/lane-1 byte pair demultiplexer.
package demux_l0_pkg;

    localparam int unsigned DATA_W_DEFAULT  = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 4;

    // WAIT0: no lane-0 byte held; WAIT1: lane-0 byte held in hold0
    typedef enum logic {
        WAIT0 = 1'b0,
        WAIT1 = 1'b1
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;
    logic [Width-1:0] cnt_d;

    // Increment unless already saturated
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    // Count register; clear takes priority over increment
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/demux_l0_pair.sv
// Splits a serial byte stream into even/odd lane pairs; a lone even byte is flushed as a
// partial pair after TIMEOUT consecutive idle cycles.
module demux_l0_pair
    import demux_l0_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk_4f,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic [15:0]       pair_cnt,
    output logic [7:0]        partial_cnt
);

    // Idle count value on which the next idle cycle triggers the partial flush
    localparam logic [7:0] IdleLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold0_q, hold0_d;
    logic [7:0]        idle_q, idle_d;
    logic [DATA_W-1:0] out0_q, out0_d;
    logic [DATA_W-1:0] out1_q, out1_d;
    logic              vout0_q, vout0_d;
    logic              vout1_q, vout1_d;
    logic              pair_inc;
    logic              partial_inc;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        hold0_d     = hold0_q;
        idle_d      = idle_q;
        out0_d      = out0_q;
        out1_d      = out1_q;
        vout0_d     = 1'b0;
        vout1_d     = 1'b0;
        pair_inc    = 1'b0;
        partial_inc = 1'b0;
        unique case (state_q)
            WAIT0: begin
                if (valid_in) begin
                    hold0_d = data_in;
                    idle_d  = '0;
                    state_d = WAIT1;
                end
            end
            WAIT1: begin
                if (valid_in) begin
                    // A valid byte always completes the pair, even on the timeout cycle
                    out0_d   = hold0_q;
                    out1_d   = data_in;
                    vout0_d  = 1'b1;
                    vout1_d  = 1'b1;
                    pair_inc = 1'b1;
                    idle_d   = '0;
                    state_d  = WAIT0;
                end else if (idle_q == IdleLast) begin
                    out0_d      = hold0_q;
                    out1_d      = '0;
                    vout0_d     = 1'b1;
                    partial_inc = 1'b1;
                    idle_d      = '0;
                    state_d     = WAIT0;
                end else begin
                    idle_d = idle_q + 8'd1;
                end
            end
            default: begin
                state_d = WAIT0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_4f) begin
        if (reset) begin
            state_q <= WAIT0;
            hold0_q <= '0;
            idle_q  <= '0;
            out0_q  <= '0;
            out1_q  <= '0;
            vout0_q <= 1'b0;
            vout1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold0_q <= hold0_d;
            idle_q  <= idle_d;
            out0_q  <= out0_d;
            out1_q  <= out1_d;
            vout0_q <= vout0_d;
            vout1_q <= vout1_d;
        end
    end

    sat_counter #(
        .Width (16)
    ) u_pair_cnt (
        .clk_i (clk_4f),
        .clr_i (reset),
        .inc_i (pair_inc),
        .cnt_o (pair_cnt)
    );

    sat_counter #(
        .Width (8)
    ) u_partial_cnt (
        .clk_i (clk_4f),
        .clr_i (reset),
        .inc_i (partial_inc),
        .cnt_o (partial_cnt)
    );

    assign data_out0  = out0_q;
    assign data_out1  = out1_q;
    assign valid_out0 = vout0_q;
    assign valid_out1 = vout1_q;

endmodule

// File: doc/demux_l0_pair.md
DEMUX_L0_PAIR -- requirements
Module: demux_l0_pair

Interface
REQ-001 Parameter DATA_W, default 8: byte width of the input and of each output lane.
REQ-002 Parameter TIMEOUT, default 4: number of consecutive idle cycles in WAIT1 before a partial pair is emitted; legal range 1..255.
REQ-003 Port clk_4f, input, 1: the block's only clock; all logic is on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port data_in, input, DATA_W: serial byte stream from upstream.
REQ-006 Port valid_in, input, 1: data_in is valid this cycle.
REQ-007 Port data_out0, output, DATA_W: lane-0 byte, the even byte of a pair.
REQ-008 Port data_out1, output, DATA_W: lane-1 byte, the odd byte of a pair.
REQ-009 Port valid_out0, output, 1: one-cycle pulse; data_out0 is valid.
REQ-010 Port valid_out1, output, 1: one-cycle pulse; data_out1 is valid.
REQ-011 Port pair_cnt, output, 16: saturating count of full pairs emitted.
REQ-012 Port partial_cnt, output, 8: saturating count of partial pairs emitted.

Function
REQ-013 Two-state FSM:
- WAIT0: no lane-0 byte is held.
- WAIT1: a lane-0 byte is held in hold0.
REQ-014 WAIT0 with valid_in=1: hold0 <= data_in; state -> WAIT1; idle counter cleared.
REQ-015 WAIT0 with valid_in=0: state unchanged; no output pulse.
REQ-016 WAIT1 with valid_in=1, emitted on the next edge:
- data_out0=hold0, data_out1=data_in;
- valid_out0=valid_out1=1;
- pair_cnt+1; state -> WAIT0.
REQ-017 Full-pair latency: outputs are valid in the cycle after the edge that samples the lane-1 byte.
REQ-018 WAIT1 with valid_in=0: idle counter +1.
REQ-019 Partial emit: when the idle counter equals TIMEOUT-1 and valid_in=0, emit on the next edge:
- data_out0=hold0, data_out1=0;
- valid_out0=1, valid_out1=0;
- partial_cnt+1; state -> WAIT0.
REQ-020 Idle cycles are counted only in WAIT1 and are consecutive; any valid byte clears the count.
REQ-021 If valid_in=1 on the cycle the timeout would fire, the full pair wins; no partial is emitted.
REQ-022 valid_out0/valid_out1 are high for exactly one cycle per emission; all other cycles they are 0.
REQ-023 data_out0/data_out1 hold their last emitted value between emissions.
REQ-024 At most one emission per cycle; with back-to-back valid input, emissions occur every second cycle.
REQ-025 pair_cnt saturates at 0xFFFF; partial_cnt saturates at 0xFF; neither wraps.
REQ-026 Byte order is preserved: the even-indexed input byte always goes to lane 0.

Reset
REQ-027 While reset=1 at an edge, all of the following are set:
- state=WAIT0;
- hold0=0, idle counter=0;
- data_out0=data_out1=0, valid_out0=valid_out1=0;
- pair_cnt=0, partial_cnt=0.
REQ-028 Reset in WAIT1 discards the held byte without any emission; the first valid byte after reset release goes to lane 0.
REQ-029 valid_in is ignored on any edge where reset=1.

Structure
REQ-030 The shared package demux_l0_pkg holds:
- the DATA_W default;
- the TIMEOUT default;
- the state enum {WAIT0, WAIT1}.
REQ-031 One sub-module, sat_counter (parameterised width, increment enable, synchronous clear), is instantiated for pair_cnt and for partial_cnt.
REQ-032 All outputs are registered; there is no combinational path from input to output.

Verification
REQ-033 Reset, then bytes 0x11,0x22 on consecutive cycles -> one cycle with data_out0=0x11, data_out1=0x22, both valids 1; pair_cnt=1.
REQ-034 Eight back-to-back bytes 0x01..0x08 -> four emissions two cycles apart, pairs (01,02),(03,04),(05,06),(07,08); pair_cnt=4.
REQ-035 Byte 0xA5 then 4 idle cycles (TIMEOUT=4) -> data_out0=0xA5, valid_out0=1, valid_out1=0, data_out1=0; partial_cnt=1.
REQ-036 Byte 0x3C, 3 idle cycles, then 0xC3 -> full pair (3C,C3); partial_cnt stays 0.
REQ-037 Byte 0x77, then reset for one cycle, then 0x10,0x20 -> no emission containing 0x77; next pair is (10,20).
REQ-038 Preload pair_cnt near 0xFFFF and stream pairs -> pair_cnt holds at 0xFFFF and does not wrap.
